// File: rtl/alu_pkg.sv
// Shared ALU package: datapath constants, status-flag struct and flag helper.
// Used by the subtract pipeline and reused by the add side of the ALU.
package alu_pkg;

    localparam int WIDTH_C = 8;
    localparam int SLICE_C = 4;

    // Status flags produced alongside an arithmetic result.
    typedef struct packed {
        logic zero;
        logic neg;
        logic ovf;
    } sub_flags_t;

    // Flags of a subtraction result. Signed overflow only happens when the
    // operand signs differ and the result sign moves away from the minuend's.
    function automatic sub_flags_t calc_sub_flags(
        input logic [WIDTH_C-1:0] diff,
        input logic               a_msb,
        input logic               b_msb
    );
        sub_flags_t flags;
        flags.zero = (diff == {WIDTH_C{1'b0}});
        flags.neg  = diff[WIDTH_C-1];
        flags.ovf  = (a_msb != b_msb) && (diff[WIDTH_C-1] != a_msb);
        return flags;
    endfunction

endpackage

// File: rtl/four_bit_subtractor.sv
// Combinational nibble subtractor: diff = a - b - bin (mod 16), bout = borrow.
// Ports:
//   a_i, b_i   4-bit operands
//   bin_i      borrow-in
//   diff_o     4-bit difference
//   bout_o     borrow-out (1 iff a < b + bin)
module four_bit_subtractor
    import alu_pkg::*;
(
    input  logic [SLICE_C-1:0] a_i,
    input  logic [SLICE_C-1:0] b_i,
    input  logic               bin_i,
    output logic [SLICE_C-1:0] diff_o,
    output logic               bout_o
);

    // One extra bit catches the borrow: a negative result wraps and sets the MSB.
    logic [SLICE_C:0] full_s;

    // Nibble subtract with borrow.
    always_comb begin
        full_s = {1'b0, a_i} - {1'b0, b_i} - {{SLICE_C{1'b0}}, bin_i};
        diff_o = full_s[SLICE_C-1:0];
        bout_o = full_s[SLICE_C];
    end

endmodule

// File: rtl/eight_bit_subtractor_pipe.sv
// Two-stage pipelined 8-bit subtractor: Diff = A - B - Bin with borrow-out and
// Zero/Neg/Ovf flags, valid/ready handshake on input and output.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   input handshake; A, B, Bin operand beat
//   out_valid / out_ready output handshake; Diff, Bout, Zero, Neg, Ovf result
// Stage 1 holds the low-nibble difference plus the raw high nibbles; stage 2
// holds the complete result. Each stage has one valid bit.
module eight_bit_subtractor_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_C,
    parameter int SLICE = SLICE_C
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero,
    output logic             Neg,
    output logic             Ovf
);

    if (WIDTH != 8 || SLICE != 4) begin : g_param_check
        $error("eight_bit_subtractor_pipe supports only WIDTH=8, SLICE=4");
    end

    // Stage 1 registers
    logic               s1_valid_q, s1_valid_d;
    logic [SLICE_C-1:0] s1_dlo_q,   s1_dlo_d;
    logic               s1_bmid_q,  s1_bmid_d;
    logic [SLICE_C-1:0] s1_ahi_q,   s1_ahi_d;
    logic [SLICE_C-1:0] s1_bhi_q,   s1_bhi_d;

    // Stage 2 registers
    logic               s2_valid_q, s2_valid_d;
    logic [WIDTH_C-1:0] s2_diff_q,  s2_diff_d;
    logic               s2_bout_q,  s2_bout_d;
    sub_flags_t         s2_flags_q, s2_flags_d;

    // Slice results and handshake terms
    logic [SLICE_C-1:0] lo_diff_s;
    logic               lo_bout_s;
    logic [SLICE_C-1:0] hi_diff_s;
    logic               hi_bout_s;
    logic               in_accept_s;
    logic               s2_load_s;

    four_bit_subtractor u_lo_slice (
        .a_i    (A[SLICE_C-1:0]),
        .b_i    (B[SLICE_C-1:0]),
        .bin_i  (Bin),
        .diff_o (lo_diff_s),
        .bout_o (lo_bout_s)
    );

    four_bit_subtractor u_hi_slice (
        .a_i    (s1_ahi_q),
        .b_i    (s1_bhi_q),
        .bin_i  (s1_bmid_q),
        .diff_o (hi_diff_s),
        .bout_o (hi_bout_s)
    );

    // Handshake: s2 refills when it is empty or draining; s1 accepts when it
    // is empty or moving into s2 this cycle. No in_valid -> out_valid path.
    always_comb begin
        s2_load_s   = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready    = !s1_valid_q || s2_load_s;
        in_accept_s = in_valid && in_ready;
    end

    // Next-state for both stages; data registers change only on their load.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_dlo_d   = s1_dlo_q;
        s1_bmid_d  = s1_bmid_q;
        s1_ahi_d   = s1_ahi_q;
        s1_bhi_d   = s1_bhi_q;
        s2_valid_d = s2_valid_q;
        s2_diff_d  = s2_diff_q;
        s2_bout_d  = s2_bout_q;
        s2_flags_d = s2_flags_q;

        if (in_accept_s) begin
            s1_valid_d = 1'b1;
            s1_dlo_d   = lo_diff_s;
            s1_bmid_d  = lo_bout_s;
            s1_ahi_d   = A[WIDTH_C-1:SLICE_C];
            s1_bhi_d   = B[WIDTH_C-1:SLICE_C];
        end else if (s2_load_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s2_load_s) begin
            s2_valid_d = 1'b1;
            s2_diff_d  = {hi_diff_s, s1_dlo_q};
            s2_bout_d  = hi_bout_s;
            s2_flags_d = calc_sub_flags({hi_diff_s, s1_dlo_q},
                                        s1_ahi_q[SLICE_C-1], s1_bhi_q[SLICE_C-1]);
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline state registers; reset flushes every beat in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_dlo_q   <= {SLICE_C{1'b0}};
            s1_bmid_q  <= 1'b0;
            s1_ahi_q   <= {SLICE_C{1'b0}};
            s1_bhi_q   <= {SLICE_C{1'b0}};
            s2_valid_q <= 1'b0;
            s2_diff_q  <= {WIDTH_C{1'b0}};
            s2_bout_q  <= 1'b0;
            s2_flags_q <= '{zero: 1'b0, neg: 1'b0, ovf: 1'b0};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_dlo_q   <= s1_dlo_d;
            s1_bmid_q  <= s1_bmid_d;
            s1_ahi_q   <= s1_ahi_d;
            s1_bhi_q   <= s1_bhi_d;
            s2_valid_q <= s2_valid_d;
            s2_diff_q  <= s2_diff_d;
            s2_bout_q  <= s2_bout_d;
            s2_flags_q <= s2_flags_d;
        end
    end

    // Result outputs come straight from the stage-2 registers.
    always_comb begin
        out_valid = s2_valid_q;
        Diff      = s2_diff_q;
        Bout      = s2_bout_q;
        Zero      = s2_flags_q.zero;
        Neg       = s2_flags_q.neg;
        Ovf       = s2_flags_q.ovf;
    end

endmodule

// File: tb/tb_eight_bit_subtractor_pipe.sv
// Self-checking bench for eight_bit_subtractor_pipe. A negedge monitor keeps a
// scoreboard queue: expected results are pushed on accept and popped/compared
// on emit. Scenario tasks add their own targeted checks.
module tb_eight_bit_subtractor_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic       Bin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] Diff;
    logic       Bout, Zero, Neg, Ovf;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       b;
        logic       z;
        logic       n;
        logic       v;
    } exp_t;

    exp_t sb[$];

    eight_bit_subtractor_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .Zero      (Zero),
        .Neg       (Neg),
        .Ovf       (Ovf)
    );

    always #5 clk = ~clk;

    // Reference: full 9-bit subtraction, borrow is the wrapped sign bit.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        logic [8:0] full;
        exp_t e;
        full = {1'b0, a} - {1'b0, b} - {8'h00, bin};
        e.d = full[7:0];
        e.b = full[8];
        e.z = (full[7:0] == 8'h00);
        e.n = full[7];
        e.v = (a[7] != b[7]) && (full[7] != a[7]);
        return e;
    endfunction

    // Scoreboard monitor: inputs/outputs are stable at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra_beat: got Diff=%h with nothing expected", Diff);
                end else begin
                    e = sb.pop_front();
                    if ({Diff, Bout, Zero, Neg, Ovf} !== e) begin
                        errors++;
                        $display("FAIL sb_result: got D=%h B=%b ZNV=%b%b%b want D=%h B=%b ZNV=%b%b%b",
                                 Diff, Bout, Zero, Neg, Ovf, e.d, e.b, e.z, e.n, e.v);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(A, B, Bin));
        end
    end

    task automatic drain(input string name);
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats still pending, want 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, Diff, Bout, Zero, Neg, Ovf, in_ready} !== {1'b0, 8'h00, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got ov=%b D=%h B=%b ZNV=%b%b%b ir=%b want ov=0 D=00 0 000 ir=1",
                     out_valid, Diff, Bout, Zero, Neg, Ovf, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        logic [7:0] va[6]  = '{8'h05, 8'h10, 8'h10, 8'h00, 8'h80, 8'h5A};
        logic [7:0] vb[6]  = '{8'h03, 8'h01, 8'h10, 8'h01, 8'h01, 8'h5A};
        logic       vc[6]  = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
        logic [7:0] ed[6]  = '{8'h02, 8'h0F, 8'h00, 8'hFF, 8'h7F, 8'hFF};
        logic [3:0] ef[6]  = '{4'b0000, 4'b0000, 4'b0100, 4'b1010, 4'b0001, 4'b1010};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; A = va[i]; B = vb[i]; Bin = vc[i];
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL directed_latency1[%0d]: out_valid=%b want 0", i, out_valid);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || Diff !== ed[i] || {Bout, Zero, Neg, Ovf} !== ef[i]) begin
                errors++;
                $display("FAIL directed[%0d]: got ov=%b D=%h BZNV=%b want ov=1 D=%h BZNV=%b",
                         i, out_valid, Diff, {Bout, Zero, Neg, Ovf}, ed[i], ef[i]);
            end
            @(posedge clk); #1;
        end
        drain("directed");
    endtask

    task automatic test_stall();
        int idx = 0;
        logic acc;
        logic [7:0] held;
        exp_t e0;
        e0 = model(8'h30, 8'h00, 1'b0);
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; A = 8'h30 + 8'(idx * 7); B = 8'(idx * 3); Bin = idx[0];
            #1 acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        checks++;
        if (idx != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_fill: accepted=%0d in_ready=%b want 2 and 0", idx, in_ready);
        end
        held = Diff;
        checks++;
        if (out_valid !== 1'b1 || held !== e0.d) begin
            errors++;
            $display("FAIL stall_head: ov=%b D=%h want ov=1 D=%h", out_valid, held, e0.d);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (Diff !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: D=%h ov=%b ir=%b want D=%h ov=1 ir=0", Diff, out_valid, in_ready, held);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 30 && idx < 6; c++) begin
            in_valid = 1'b1; A = 8'h30 + 8'(idx * 7); B = 8'(idx * 3); Bin = idx[0];
            #1 acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 6) begin
            errors++;
            $display("FAIL stall_accepts: accepted=%0d want 6", idx);
        end
        drain("stall");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
            #1;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== (i >= 2)) begin
                errors++;
                $display("FAIL b2b[%0d]: ir=%b ov=%b want ir=1 ov=%b", i, in_ready, out_valid, (i >= 2));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain("b2b");
    endtask

    task automatic test_random();
        int beats = 0;
        logic acc = 1'b0;
        for (int c = 0; c < 40000 && beats < 10000; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1 acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) beats++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (beats != 10000) begin
            errors++;
            $display("FAIL random_beats: accepted=%0d want 10000", beats);
        end
        drain("random");
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; A = 8'h44 + 8'(i); B = 8'h11; Bin = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_full: ov=%b ir=%b want ov=1 ir=0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || Diff !== 8'h00 || {Bout, Zero, Neg, Ovf} !== 4'b0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_async: ov=%b D=%h BZNV=%b ir=%b want 0 00 0000 1",
                     out_valid, Diff, {Bout, Zero, Neg, Ovf}, in_ready);
        end
        sb.delete();
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_stale[%0d]: out_valid=%b want 0", c, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
